// File: rtl/dmem_mmio_responder_if.sv
// Data-memory bus between the core (master) and the responder (slave).
// Store strobe, byte address and store data go out; load data comes back.
interface dmem_mmio_responder_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output MemWrite,
        output ALUResult,
        output WriteData,
        input  ReadData
    );

    modport slave (
        input  MemWrite,
        input  ALUResult,
        input  WriteData,
        output ReadData
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus LED/CYCLE/CMP/STATUS register block.
// Define DMEM_FAULT_CAPTURE_EN to add the FAULT_ADDR register at offset 0x10.
module dmem_mmio_responder #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned LED_W     = 8,
    parameter logic [31:0] MMIO_BASE = 32'h0000_0400
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dmem_mmio_responder_if.slave bus,
    output logic [LED_W-1:0]     leds,
    output logic                 cmp_irq
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    localparam logic [2:0] R_LED    = 3'd0;
    localparam logic [2:0] R_CYCLE  = 3'd1;
    localparam logic [2:0] R_CMP    = 3'd2;
    localparam logic [2:0] R_STATUS = 3'd3;
`ifdef DMEM_FAULT_CAPTURE_EN
    localparam logic [2:0] R_FAULT  = 3'd4;
`endif

    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      off;
    logic [2:0]       sel;
    logic [AW-1:0]    idx;
    logic             aligned;
    logic             ram_hit;
    logic             reg_hit;
    logic             wr;
    logic             wr_ram;
    logic             wr_reg;
    logic             misal;
    logic             wr_led;
    logic             wr_cycle;
    logic             wr_cmp;
    logic             wr_status;
    logic             match;

    logic [31:0]      mem [DEPTH];
    logic [LED_W-1:0] led_q;
    logic [31:0]      cycle_q;
    logic [31:0]      cmp_q;
    logic [1:0]       status_q;
    logic [1:0]       status_d;
    logic [31:0]      rdata;
`ifdef DMEM_FAULT_CAPTURE_EN
    logic [31:0]      fault_q;
`endif

    // Address decode; MMIO_BASE sits above the RAM so the hits never overlap.
    assign addr    = bus.ALUResult;
    assign wdata   = bus.WriteData;
    assign off     = addr - MMIO_BASE;
    assign sel     = off[4:2];
    assign idx     = addr[AW+1:2];
    assign aligned = (addr[1:0] == 2'b00);
    assign ram_hit = (addr < RAM_BYTES);
    assign reg_hit = (addr >= MMIO_BASE)
                  && (off < 32'd32);

    assign wr     = bus.MemWrite && aligned;
    assign misal  = bus.MemWrite && !aligned;
    assign wr_ram = wr && ram_hit;
    assign wr_reg = wr && reg_hit;

    assign wr_led    = wr_reg && (sel == R_LED);
    assign wr_cycle  = wr_reg && (sel == R_CYCLE);
    assign wr_cmp    = wr_reg && (sel == R_CMP);
    assign wr_status = wr_reg && (sel == R_STATUS);

    assign match = (cycle_q == cmp_q);

    // Sticky flags: a fresh event beats a coincident write-1-clear.
    always_comb begin
        status_d    = status_q;
        status_d[0] = match
                   || (status_q[0]
                   && !(wr_status && wdata[0]));
        status_d[1] = misal
                   || (status_q[1]
                   && !(wr_status && wdata[1]));
    end

    // Zero-latency load path.
    always_comb begin
        rdata = '0;
        if (aligned && ram_hit) begin
            rdata = mem[idx];
        end else if (aligned && reg_hit) begin
            case (sel)
                R_LED:    rdata = 32'(led_q);
                R_CYCLE:  rdata = cycle_q;
                R_CMP:    rdata = cmp_q;
                R_STATUS: rdata = {30'd0, status_q};
`ifdef DMEM_FAULT_CAPTURE_EN
                R_FAULT:  rdata = fault_q;
`endif
                default:  rdata = '0;
            endcase
        end
    end

    assign bus.ReadData = rdata;

    // RAM is never cleared; reset only blocks a store in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (reset_n && wr_ram) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q    <= '0;
            cycle_q  <= '0;
            cmp_q    <= '1;
            status_q <= '0;
        end else begin
            if (wr_led) begin
                led_q <= wdata[LED_W-1:0];
            end
            if (wr_cycle) begin
                cycle_q <= '0;
            end else begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (wr_cmp) begin
                cmp_q <= wdata;
            end
            status_q <= status_d;
        end
    end

`ifdef DMEM_FAULT_CAPTURE_EN
    // Holds the first faulting address until bit1 is cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= '0;
        end else if (misal && !status_q[1]) begin
            fault_q <= addr;
        end else if (wr_status && wdata[1]) begin
            fault_q <= '0;
        end
    end
`endif

    assign leds    = led_q;
    assign cmp_irq = status_q[0];
endmodule
